// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
// Width rules and the round-robin pick used by obi_rr_arbiter.
package obi_arb_pkg;

  localparam int MaxMgr = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } pick_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

  // First requester at or after prio, wrapping at n.
  function automatic pick_t rr_pick(
    input logic [MaxMgr-1:0] req,
    input int unsigned       prio,
    input int unsigned       n
  );
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned i = 0; i < MaxMgr; i++) begin
      if (i < n) begin
        j = prio + i;
        if (j >= n) j = j - n;
        if (!p.valid && req[j[4:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[4:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/obi_arb_idq.sv
// In-order ID queue: FIFO of winner indices awaiting a response.
// Push is dropped when full, pop is dropped when empty.
module obi_arb_idq
  import obi_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int CntWidth = cnt_width(Depth);
  localparam int PtrWidth = idx_width(Depth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;
  logic [CntWidth-1:0] cnt;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (cnt == CntWidth'(Depth));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok)
        wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
      if (pop_ok)
        rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: NumMgr managers onto one subordinate port.
// Define OBI_ARB_ERRCHK_EN to add the sticky unexp_rsp_o flag.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NumMgr    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxTrans  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
`ifdef OBI_ARB_ERRCHK_EN
  output logic                          unexp_rsp_o,
`endif
  input  logic [NumMgr-1:0]             mgr_req_i,
  output logic [NumMgr-1:0]             mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]             mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
  output logic [NumMgr-1:0]             mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic                          sbr_req_o,
  input  logic                          sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  input  logic                          sbr_rvalid_i,
  input  logic [DataWidth-1:0]          sbr_rdata_i,
  input  logic                          sbr_err_i
);

  localparam int IdxWidth = idx_width(NumMgr);
  localparam int BeWidth  = DataWidth / 8;
  localparam logic [IdxWidth-1:0] LastMgr = IdxWidth'(NumMgr - 1);

  logic [IdxWidth-1:0] prio_q;
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic [MaxMgr-1:0]   req_ext;
  pick_t               pick;
  logic [IdxWidth-1:0] winner;
  logic                win_req;
  logic                hs;
  logic                pop;
  logic                full;
  logic                empty;
  logic [IdxWidth-1:0] head;
  logic                unused_pick;

  always_comb begin
    req_ext = '0;
    req_ext[NumMgr-1:0] = mgr_req_i;
  end

  assign pick        = rr_pick(req_ext, 32'(prio_q), NumMgr);
  assign unused_pick = ^pick.idx;
  assign winner  = lock_q ? lock_idx_q : pick.idx[IdxWidth-1:0];
  assign win_req = lock_q ? mgr_req_i[lock_idx_q] : pick.valid;

  assign sbr_req_o = win_req & ~full & ~rst_i;
  assign hs        = sbr_req_o & sbr_gnt_i;
  assign pop       = sbr_rvalid_i & ~empty & ~rst_i;

  assign sbr_addr_o  = sbr_req_o ?
    mgr_addr_i[winner*AddrWidth +: AddrWidth] : '0;
  assign sbr_we_o    = sbr_req_o & mgr_we_i[winner];
  assign sbr_be_o    = sbr_req_o ?
    mgr_be_i[winner*BeWidth +: BeWidth] : '0;
  assign sbr_wdata_o = sbr_req_o ?
    mgr_wdata_i[winner*DataWidth +: DataWidth] : '0;

  always_comb begin
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    if (hs)  mgr_gnt_o[winner]  = 1'b1;
    if (pop) mgr_rvalid_o[head] = 1'b1;
  end

  assign mgr_rdata_o = sbr_rdata_i;
  assign mgr_err_o   = sbr_err_i;

  // A presented but ungranted request pins the winner until accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      prio_q <= (winner == LastMgr) ? '0 : winner + 1'b1;
      lock_q <= 1'b0;
    end else if (sbr_req_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

  obi_arb_idq #(
    .Depth (MaxTrans),
    .Width (IdxWidth)
  ) u_idq (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs),
    .pop   (pop),
    .din   (winner),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef OBI_ARB_ERRCHK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      unexp_rsp_o <= 1'b0;
    else if (sbr_rvalid_i & empty)
      unexp_rsp_o <= 1'b1;
  end
`endif

endmodule

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

Round-robin arbiter that shares one OBI subordinate port (e.g. the user-domain subordinate bus toward the core domain) between `NumMgr` OBI managers. It arbitrates requests and holds the selection stable until grant, as OBI requires. It records the winner of every accepted request in an in-order ID queue so each response is returned to the manager that issued it. It sits between the user-domain managers and the single manager-side OBI link out of the user domain.

## Interface
Parameters:
- `NumMgr`, 2: number of requesting managers, ≥2.
- `AddrWidth`, 32: OBI address width.
- `DataWidth`, 32: OBI data width; byte-enable width is `DataWidth/8`.
- `MaxTrans`, 2: outstanding-transaction capacity (ID queue depth), ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, asynchronous, active-high.
- `mgr_req_i`  in  NumMgr  per-manager request.
- `mgr_gnt_o`  out  NumMgr  per-manager grant.
- `mgr_addr_i`  in  NumMgr×AddrWidth  packed addresses, manager i at slice i.
- `mgr_we_i`  in  NumMgr  write enables.
- `mgr_be_i`  in  NumMgr×DataWidth/8  byte enables.
- `mgr_wdata_i`  in  NumMgr×DataWidth  write data.
- `mgr_rvalid_o`  out  NumMgr  per-manager response valid.
- `mgr_rdata_o`  out  DataWidth  response data, broadcast to all managers.
- `mgr_err_o`  out  1  response error, broadcast to all managers.
- `sbr_req_o` / `sbr_gnt_i`  out/in  1  subordinate-side request handshake.
- `sbr_addr_o`, `sbr_we_o`, `sbr_be_o`, `sbr_wdata_o`  out  as above  selected request fields.
- `sbr_rvalid_i`, `sbr_rdata_i`, `sbr_err_i`  in  1/DataWidth/1  subordinate response.

## Operation
- State: round-robin pointer `prio_q` (0..NumMgr-1); lock flag plus locked index; ID queue of manager indices (depth `MaxTrans`).
- Arbitration, unlocked: the winner is the first requesting manager found scanning from `prio_q` upward, with wrap-around.
- Arbitration, locked: the winner is the locked index, regardless of other requests.
- Queue full: `sbr_req_o`=0, all `mgr_gnt_o`=0, pointer and lock unchanged.
- Otherwise, `sbr_req_o` = winner's request. The `sbr_*` fields are muxed from the winner; they are zero when there is no request.
- `mgr_gnt_o[winner]` = `sbr_gnt_i`; all other grants are 0.
- Handshake (`sbr_req_o & sbr_gnt_i`):
  - push the winner index into the queue;
  - set `prio_q` = (winner+1) mod NumMgr;
  - clear the lock.
- Request without grant: the lock is set to the winner, so the next cycle presents the same manager.
- Response: `sbr_rvalid_i` pops the queue head. `mgr_rvalid_o[head]`=1 in the same cycle; all other rvalids are 0. `rdata`/`err` pass straight through.
- Responses are strictly in order; the arbiter never reorders.
- Push and pop in the same cycle when the queue is not full: both happen and the occupancy is unchanged.
- Full queue with a pop in the same cycle: the push is still blocked (the full check uses the registered count).
- `sbr_rvalid_i` with an empty queue is a protocol violation:
  - all `mgr_rvalid_o` stay 0;
  - there is no pop and no underflow.
- Reset mid-transaction: the queue is flushed, the pointer goes to 0 and the lock is cleared. Any in-flight responses are discarded.

## Timing
- Reset values: `prio_q`=0, lock=0, queue empty.
- Outputs while `rst_i` is asserted (only `mgr_rdata_o`/`mgr_err_o` follow the subordinate inputs):
  - `sbr_req_o`=0, `mgr_gnt_o`=0, `mgr_rvalid_o`=0;
  - all `sbr_*` field outputs 0;
  - `mgr_rdata_o`/`mgr_err_o` pass through the subordinate response inputs.
- Zero-cycle request path: `mgr_req_i` to `sbr_req_o`, and `sbr_gnt_i` to `mgr_gnt_o`, are combinational.
- Zero-cycle response path: `sbr_rvalid_i` to `mgr_rvalid_o` is combinational through the registered queue head.
- The pointer, lock and queue update on the rising edge after the handshake or response.
- Throughput: one grant per cycle while the queue is not full. With `MaxTrans`=1, back-to-back grants need the response in between.

## Configuration
- `OBI_ARB_ERRCHK_EN` defined:
  - adds output `unexp_rsp_o` (1 bit);
  - it is sticky and set on `sbr_rvalid_i` with an empty queue;
  - it is cleared only by `rst_i`, with reset value 0.
- Not defined: the port is absent and unexpected responses are silently ignored.

## Structure
- Shared package `obi_arb_pkg` holds the following, derived from parameters inside the module:
  - function `rr_pick(req, prio)`, which returns the index and a valid flag;
  - localparam rules for `IdxWidth = $clog2(NumMgr)` and `CntWidth = $clog2(MaxTrans+1)`.
- Sub-module `obi_arb_idq`: a synchronous FIFO of `IdxWidth`-bit entries with push, pop, full, empty and head.
  - Pointers wrap modulo `MaxTrans`, and the count saturates nowhere.
  - It is parameterised by depth and uses the same asynchronous active-high reset.

## Test plan
- **Single request:** mgr0 issues a read at 0x1000 with `sbr_gnt_i`=1.
  - Expect `mgr_gnt_o`=01 in the same cycle.
  - Return `sbr_rvalid_i` with rdata 0xDEADBEEF two cycles later: `mgr_rvalid_o`=01 and `mgr_rdata_o`=0xDEADBEEF.
- **Round-robin fairness:** both managers request continuously, gnt always 1, responses returned each cycle.
  - Grants alternate 01,10,01,10, starting with mgr0 after reset.
- **Grant stall lock:** mgr1 requests with `sbr_gnt_i`=0 for 3 cycles while mgr0 asserts a request in cycle 2.
  - `sbr_addr_o` stays at mgr1's address throughout; mgr1 is granted first once gnt=1.
- **Full queue (MaxTrans=2):** two grants with no response.
  - The third request sees `sbr_req_o`=0 until one `sbr_rvalid_i` arrives; the grant follows in the next cycle.
- **In-order routing:** mgr0 then mgr1 are granted; responses R0 (err=0) and R1 (err=1) are returned.
  - `mgr_rvalid_o`=01 then 10, with `mgr_err_o` 0 then 1.
- **Reset and unexpected response:** assert `rst_i` with 2 outstanding transactions, then pulse `sbr_rvalid_i`.
  - No `mgr_rvalid_o`; with `OBI_ARB_ERRCHK_EN`, `unexp_rsp_o`=1.
